button_debouncer: RTL and testbench

- Upstream conditioning stage for the edge detector. Takes a raw, asynchronous, bouncing push-button/switch input and produces a clean, clock-synchronous level.
- The output level drives the detector's enable input directly. The detector then yields one pulse per real press, e.g. for VGA mode/colour stepping.
- Internally: 2-flop synchroniser, then a 4-state debounce FSM with a stability counter.

---
 rtl/button_debouncer.sv | 124 ++++++++++++
 tb/tb_button_debouncer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Button debouncer: 2-flop synchroniser followed by a 4-state debounce FSM.
// A new synchronised level must hold for STABLE_CYCLES consecutive cycles
// in a WAIT state before o_level follows it. A reversal during WAIT aborts
// the change and raises a one-cycle o_glitch pulse.
//
// Ports:
//   clk      system clock, rising edge
//   i_arst   asynchronous reset, active-high (priority over i_sclr)
//   i_sclr   synchronous clear, active-high (same effect as reset)
//   i_btn    raw asynchronous button input
//   o_level  debounced level (registered)
//   o_glitch one-cycle pulse when a pending change is aborted (registered)
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic i_arst,
  input  logic i_sclr,
  input  logic i_btn,
  output logic o_level,
  output logic o_glitch
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_ff1;
  logic             sync_ff2;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             glitch_d;

  // Two-flop synchroniser; nothing sits in front of the first flop.
  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else if (i_sclr) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= i_btn;
      sync_ff2 <= sync_ff1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      o_level  <= 1'b0;
      o_glitch <= 1'b0;
    end else if (i_sclr) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      o_level  <= 1'b0;
      o_glitch <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_level  <= level_d;
      o_glitch <= glitch_d;
    end
  end

  // Next-state logic; a reversal in WAIT restarts from the stable state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync_ff2) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync_ff2) begin
          state_d  = ST_LOW;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!sync_ff2) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (sync_ff2) begin
          state_d  = ST_HIGH;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
    // Level is registered from the next state so it never decodes glitches.
    level_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios followed by a
// randomized phase, all compared against a run-length reference model.
module tb_button_debouncer;

  localparam int unsigned STABLE = 4;
  localparam int unsigned CW     = 20;

  logic clk = 1'b0;
  logic i_arst;
  logic i_sclr;
  logic i_btn;
  logic o_level;
  logic o_glitch;

  int n_cmp = 0;
  int n_bad = 0;
  int glitch_seen = 0;

  // Reference model state: sampled-input history, current level, run length
  // of consecutive samples that disagree with the level, and glitch output.
  bit q[$];
  bit m_lvl;
  bit m_glitch;
  int m_run;

  button_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
    .clk     (clk),
    .i_arst  (i_arst),
    .i_sclr  (i_sclr),
    .i_btn   (i_btn),
    .o_level (o_level),
    .o_glitch(o_glitch)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q = {1'b0, 1'b0};
    m_lvl = 1'b0;
    m_glitch = 1'b0;
    m_run = 0;
  endtask

  // Level flips once the input has disagreed with it on STABLE+1 consecutive
  // sampled edges (one to notice, STABLE to qualify); an interrupted run
  // produces a glitch pulse.
  task automatic model_edge(input bit btn, input bit sclr);
    bit s;
    if (sclr) begin
      model_reset();
    end else begin
      s = q.pop_front();
      q.push_back(btn);
      m_glitch = 1'b0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == int'(STABLE) + 1) begin
          m_lvl = s;
          m_run = 0;
        end
      end else begin
        m_glitch = (m_run > 0);
        m_run = 0;
      end
    end
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (o_level === m_lvl) else begin
      n_bad++;
      $error("FAIL %s level t=%0t got %b exp %b", tag, $time, o_level, m_lvl);
    end
    n_cmp++;
    assert (o_glitch === m_glitch) else begin
      n_bad++;
      $error("FAIL %s glitch t=%0t got %b exp %b", tag, $time, o_glitch, m_glitch);
    end
  endtask

  // Drive inputs away from the edge, clock once, update model, sample at +1.
  task automatic tick(input logic btn, input logic sclr, input string tag);
    i_btn  = btn;
    i_sclr = sclr;
    @(posedge clk);
    model_edge(btn, sclr);
    #1;
    if (o_glitch === 1'b1) glitch_seen++;
    check(tag);
  endtask

  initial begin
    int rise_edge;
    int cycles;
    logic b;
    logic c;
    int hold;

    // Reset
    i_arst = 1'b1;
    i_sclr = 1'b0;
    i_btn  = 1'b0;
    model_reset();
    #12;
    check("reset");
    i_arst = 1'b0;
    @(posedge clk);
    #1;
    model_edge(1'b0, 1'b0);
    check("post_reset");

    // 1: clean press, level must rise after exactly edge 7
    glitch_seen = 0;
    rise_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1, 1'b0, "press");
      if (o_level === 1'b1 && rise_edge == 0) rise_edge = e;
    end
    n_cmp++;
    assert (rise_edge == int'(STABLE) + 3) else begin
      n_bad++;
      $error("FAIL press_latency got %0d exp %0d", rise_edge, STABLE + 3);
    end
    n_cmp++;
    assert (glitch_seen == 0) else begin
      n_bad++;
      $error("FAIL press_glitch_count got %0d exp 0", glitch_seen);
    end

    // 3: clean release, drop after edge 7
    rise_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b0, 1'b0, "release");
      if (o_level === 1'b0 && rise_edge == 0) rise_edge = e;
    end
    n_cmp++;
    assert (rise_edge == int'(STABLE) + 3) else begin
      n_bad++;
      $error("FAIL release_latency got %0d exp %0d", rise_edge, STABLE + 3);
    end

    // 2: bounce during press: 1,1,1,0 then held 1
    glitch_seen = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "bounce_press");
    tick(1'b0, 1'b0, "bounce_press");
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, "bounce_press");
    n_cmp++;
    assert (glitch_seen == 1) else begin
      n_bad++;
      $error("FAIL bounce_press_glitch_count got %0d exp 1", glitch_seen);
    end

    // 4: release bounce: 0,1 then held 0
    glitch_seen = 0;
    tick(1'b0, 1'b0, "bounce_release");
    tick(1'b1, 1'b0, "bounce_release");
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, "bounce_release");
    n_cmp++;
    assert (glitch_seen == 1) else begin
      n_bad++;
      $error("FAIL bounce_release_glitch_count got %0d exp 1", glitch_seen);
    end

    // 5: clear while WAIT_HIGH with cnt=2 (after edge 5 of the press)
    glitch_seen = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, "clear_wait");
    tick(1'b1, 1'b1, "clear_wait");
    rise_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b1, 1'b0, "clear_requal");
      if (o_level === 1'b1 && rise_edge == 0) rise_edge = e;
    end
    n_cmp++;
    assert (rise_edge == int'(STABLE) + 3) else begin
      n_bad++;
      $error("FAIL clear_requal_latency got %0d exp %0d", rise_edge, STABLE + 3);
    end
    n_cmp++;
    assert (glitch_seen == 0) else begin
      n_bad++;
      $error("FAIL clear_glitch_count got %0d exp 0", glitch_seen);
    end

    // 6: async reset between edges while HIGH, button still pressed
    #2;
    i_arst = 1'b1;
    #1;
    model_reset();
    check("async_reset");
    #2;
    i_arst = 1'b0;
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, "after_arst");

    // Randomized bursts with occasional synchronous clears
    cycles = 0;
    while (cycles < 2000) begin
      hold = int'($urandom_range(1, 8));
      b = 1'($urandom_range(0, 1));
      for (int i = 0; i < hold; i++) begin
        c = ($urandom_range(0, 63) == 0);
        tick(b, c, "random");
        cycles++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
